// File: rtl/blackjack_pkg.sv
// rtl/blackjack_pkg.sv - shared deck sizes, card/index types and dealer FSM states
package blackjack_pkg;

   localparam int DECK_SIZE = 52;
   localparam int ADDR_W    = 6;
   localparam int VAL_W     = 4;

   typedef logic [VAL_W-1:0]  card_val_t;
   typedef logic [ADDR_W-1:0] deck_idx_t;

   typedef enum logic [1:0] {IDLE, PROBE, FETCH, CAPTURE} dealer_state_t;

   localparam deck_idx_t DECK_FULL = deck_idx_t'(DECK_SIZE);
   localparam deck_idx_t DECK_LAST = deck_idx_t'(DECK_SIZE - 1);

   // Fold a 6-bit random value (0..63) into a legal slot (0..51).
   function automatic deck_idx_t fold_start(input deck_idx_t raw);
      return (raw >= DECK_FULL) ? raw - DECK_FULL : raw;
   endfunction

endpackage

// File: rtl/card_dealer_lfsr8.sv
// rtl/card_dealer_lfsr8.sv - free-running 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1
module lfsr8 (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] seed,
   output logic [7:0] q
);

   // Advance every cycle; feedback from bits 7,5,4,3 shifts in at bit 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) q <= seed;
      else       q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   end

endmodule

// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - deals cards without replacement from the card ROM (DEALER_SEQUENTIAL_EN: deal in ROM order)
module card_dealer
   import blackjack_pkg::*;
#(
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              draw,
   input  logic              shuffle,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [VAL_W-1:0]  rom_data,
   output logic              card_valid,
   output logic [VAL_W-1:0]  card_value,
   output logic [ADDR_W-1:0] card_index,
   output logic [ADDR_W-1:0] cards_left,
   output logic              deck_empty,
   output logic              busy,
   output logic              draw_err
);

   dealer_state_t          state, state_nx;
   logic [DECK_SIZE-1:0]   used;
   deck_idx_t              idx;
   deck_idx_t              start_idx;
   logic [7:0]             lfsr_q;
   logic                   unused_lfsr;
   logic                   do_shuffle, do_start, do_err, do_take, do_step, do_capture;

   lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .q     (lfsr_q)
   );

   // Parity of the whole LFSR keeps every generator bit referenced in both builds.
   assign unused_lfsr = ^lfsr_q;

`ifdef DEALER_SEQUENTIAL_EN
   assign start_idx = '0;
`else
   assign start_idx = fold_start(lfsr_q[5:0]);
`endif

   assign deck_empty = (cards_left == '0);

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state: shuffle beats draw, probing stops on the first free slot.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (!shuffle && draw && !deck_empty) state_nx = PROBE;
         PROBE:   if (!used[idx]) state_nx = FETCH;
         FETCH:   state_nx = CAPTURE;
         CAPTURE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Per-state strobes steering the datapath registers.
   always_comb begin
      busy       = (state != IDLE);
      do_shuffle = (state == IDLE) && shuffle;
      do_err     = (state == IDLE) && !shuffle && draw && deck_empty;
      do_start   = (state == IDLE) && !shuffle && draw && !deck_empty;
      do_take    = (state == PROBE) && !used[idx];
      do_step    = (state == PROBE) && used[idx];
      do_capture = (state == CAPTURE);
   end

   // Deck mask, probe index, ROM address and registered card outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         used       <= '0;
         idx        <= '0;
         cards_left <= DECK_FULL;
         rom_addr   <= '0;
         card_value <= '0;
         card_index <= '0;
         card_valid <= 1'b0;
         draw_err   <= 1'b0;
      end else begin
         card_valid <= do_capture;
         draw_err   <= do_err;
         if (do_shuffle) begin
            used       <= '0;
            cards_left <= DECK_FULL;
         end
         if (do_start) idx <= start_idx;
         if (do_step)  idx <= (idx == DECK_LAST) ? '0 : idx + 1'b1;
         if (do_take) begin
            used[idx]  <= 1'b1;
            rom_addr   <= idx;
            cards_left <= cards_left - 1'b1;
         end
         if (do_capture) begin
            card_value <= rom_data;
            card_index <= rom_addr;
         end
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - scoreboard bench for card_dealer with card ROM and deck model
module tb_card_dealer;
   import blackjack_pkg::*;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              draw = 1'b0;
   logic              shuffle = 1'b0;
   logic [ADDR_W-1:0] rom_addr, card_index, cards_left;
   logic [VAL_W-1:0]  rom_data, card_value;
   logic              card_valid, deck_empty, busy, draw_err;

   card_dealer dut (
      .clk        (clk),
      .reset      (reset),
      .draw       (draw),
      .shuffle    (shuffle),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .card_valid (card_valid),
      .card_value (card_value),
      .card_index (card_index),
      .cards_left (cards_left),
      .deck_empty (deck_empty),
      .busy       (busy),
      .draw_err   (draw_err)
   );

   always #5 clk = ~clk;

   function automatic int card_of(input int slot);
      int r;
      r = slot % 13 + 1;
      return (r > 10) ? 10 : r;
   endfunction

   // Card ROM: one-cycle registered read.
   always @(posedge clk) rom_data <= VAL_W'(card_of(int'(rom_addr)));

   int     errors = 0;
   int     checks = 0;
   longint cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Reference deck: a free/used flag per slot, count remaining, and the generator sequence.
   bit         m_used [DECK_SIZE];
   int         m_left;
   logic [7:0] m_lfsr;
   int         exp_err = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) m_lfsr <= 8'hA5;
      else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   typedef struct {
      int     idx;
      int     val;
      int     left;
      longint cyc;
   } exp_t;

   exp_t sb[$];

   // Monitor-side statistics of dealt cards.
   bit     seen [DECK_SIZE];
   int     vcnt [11];
   int     vsum;
   int     err_seen = 0;
   exp_t   e;

   task automatic clear_stats();
      foreach (seen[i]) seen[i] = 1'b0;
      foreach (vcnt[i]) vcnt[i] = 0;
      vsum = 0;
   endtask

   task automatic model_fresh_deck();
      foreach (m_used[i]) m_used[i] = 1'b0;
      m_left = DECK_SIZE;
   endtask

   // Monitor: compare every presented card against the oldest expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (draw_err) err_seen++;
         if (card_valid) begin
            if (sb.size() == 0) begin
               check("card_expected", sb.size(), 1);
            end else begin
               e = sb.pop_front();
               check("card_index", card_index, e.idx);
               check("card_value", card_value, e.val);
               check("cards_left_at_card", cards_left, e.left);
               check("card_latency_cycle", 32'(cyc), 32'(e.cyc));
               check("card_distinct", seen[int'(card_index) % DECK_SIZE], 0);
               seen[int'(card_index) % DECK_SIZE] = 1'b1;
               vcnt[int'(card_value) % 11]++;
               vsum += int'(card_value);
            end
         end
      end
   end

   // Issue one draw at a negedge; optionally poke draw+shuffle while the deal is in flight.
   task automatic issue_draw(input bit poke);
      int   s;
      int   k;
      exp_t x;
      if (m_left == 0) begin
         exp_err++;
      end else begin
`ifdef DEALER_SEQUENTIAL_EN
         s = 0;
`else
         s = int'(m_lfsr[5:0]);
         if (s >= DECK_SIZE) s -= DECK_SIZE;
`endif
         k = 0;
         while (m_used[(s + k) % DECK_SIZE]) k++;
         x.idx  = (s + k) % DECK_SIZE;
         m_used[x.idx] = 1'b1;
         m_left--;
         x.left = m_left;
         x.val  = card_of(x.idx);
         x.cyc  = cyc + 4 + k;
         sb.push_back(x);
      end
      draw = 1'b1;
      @(negedge clk);
      draw = 1'b0;
      if (poke) begin
         draw    = 1'b1;
         shuffle = 1'b1;
         @(negedge clk);
         draw    = 1'b0;
         shuffle = 1'b0;
      end
      for (int n = 0; n < 80 && busy; n++) @(negedge clk);
      check("deal_done", busy, 0);
   endtask

   initial begin
      model_fresh_deck();
      clear_stats();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("rst_cards_left", cards_left, 52);
      check("rst_deck_empty", deck_empty, 0);
      check("rst_busy", busy, 0);
      check("rst_rom_addr", rom_addr, 0);
      check("rst_card_value", card_value, 0);
      check("rst_card_index", card_index, 0);
      check("rst_card_valid", card_valid, 0);
      check("rst_draw_err", draw_err, 0);

      // Full deck dealt with random idle gaps between draws.
      for (int i = 0; i < DECK_SIZE; i++) begin
         issue_draw(1'b0);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      @(negedge clk);
      check("deck_empty_after_52", deck_empty, 1);
      check("cards_left_after_52", cards_left, 0);
      check("value_sum", vsum, 340);
      for (int v = 1; v <= 9; v++) check($sformatf("value_%0d_count", v), vcnt[v], 4);
      check("value_10_count", vcnt[10], 16);
      check("queue_drained_52", sb.size(), 0);

      // 53rd draw on an empty deck.
      issue_draw(1'b0);
      repeat (3) @(negedge clk);
      check("empty_draw_err_pulses", err_seen, exp_err);
      check("empty_cards_left", cards_left, 0);

      // Shuffle and draw together: shuffle wins, nothing dealt.
      shuffle = 1'b1;
      draw    = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      draw    = 1'b0;
      model_fresh_deck();
      clear_stats();
      check("shuffle_draw_busy", busy, 0);
      repeat (2) @(negedge clk);
      check("shuffle_cards_left", cards_left, 52);
      check("shuffle_deck_empty", deck_empty, 0);
      check("shuffle_busy_later", busy, 0);

      // Draw and shuffle while busy are ignored.
      issue_draw(1'b1);
      repeat (2) @(negedge clk);
      check("busy_ignore_cards_left", cards_left, 51);

      // Reset while the dealer sits in FETCH.
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      model_fresh_deck();
      draw = 1'b1;
      @(negedge clk);
      draw = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      sb.delete();
      model_fresh_deck();
      #1;
      check("midreset_busy", busy, 0);
      check("midreset_cards_left", cards_left, 52);
      check("midreset_rom_addr", rom_addr, 0);
      check("midreset_card_valid", card_valid, 0);
      check("midreset_card_value", card_value, 0);
      check("midreset_card_index", card_index, 0);
      @(negedge clk);
      reset = 1'b0;
      clear_stats();
      @(negedge clk);
      issue_draw(1'b0);
      @(negedge clk);
      check("after_reset_cards_left", cards_left, 51);
      for (int i = 0; i < 6; i++) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         issue_draw(1'b0);
      end

      repeat (6) @(negedge clk);
      check("final_queue_drained", sb.size(), 0);
      check("final_draw_err_pulses", err_seen, exp_err);
      check("final_cards_left", cards_left, m_left);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
